// File: rtl/apb_master_bridge.sv
// Parametrised APB2 master bridge: one valid/ready request decoded onto NSLV slaves.
// Latency: accept@N, SETUP N+1, ACCESS N+2.., rsp_valid one cycle after ACCESS/ERR exit.
// Backpressure: req_ready only in IDLE; PREADY stretches ACCESS up to TIMEOUT cycles; rsp never stalls.
module apb_master_bridge #(
  parameter int AW      = 9,
  parameter int DW      = 8,
  parameter int NSLV    = 2,
  parameter int TIMEOUT = 16,
  localparam int SW     = $clog2(NSLV)
) (
  input  logic                 PCLK,
  input  logic                 PRESETn,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [AW-1:0]        req_addr,
  input  logic [DW-1:0]        req_wdata,
  output logic                 rsp_valid,
  output logic [DW-1:0]        rsp_rdata,
  output logic                 rsp_err,
  output logic [NSLV-1:0]      PSEL,
  output logic                 PENABLE,
  output logic                 PWRITE,
  output logic [AW-SW-1:0]     PADDR,
  output logic [DW-1:0]        PWDATA,
  input  logic [NSLV*DW-1:0]   PRDATA,
  input  logic [NSLV-1:0]      PREADY,
  input  logic [NSLV-1:0]      PSLVERR
);

  localparam int              CW      = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0]   TO_LAST = CW'(TIMEOUT - 1);
  localparam logic [SW:0]     NSLV_L  = (SW+1)'(NSLV);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, ERR} state_t;

  state_t          state, state_nxt;
  logic [AW-1:0]   addr_q;
  logic            write_q;
  logic [DW-1:0]   wdata_q;
  logic [CW-1:0]   cnt;
  logic [SW-1:0]   idx;
  logic [SW-1:0]   req_idx;
  logic            req_mapped;
  logic            pready_sel;
  logic            pslverr_sel;
  logic [DW-1:0]   prdata_sel;
  logic [NSLV-1:0] sel_onehot;
  logic            timeout_hit;
  logic            access_done;

  assign idx        = addr_q[AW-1 -: SW];
  assign req_idx    = req_addr[AW-1 -: SW];
  assign req_mapped = {1'b0, req_idx} < NSLV_L;

  assign PADDR  = addr_q[AW-SW-1:0];
  assign PWRITE = write_q;
  assign PWDATA = wdata_q;

  // Pick the addressed slave's return signals; all other slaves are ignored.
  always_comb begin
    pready_sel  = 1'b0;
    pslverr_sel = 1'b0;
    prdata_sel  = '0;
    sel_onehot  = '0;
    for (int i = 0; i < NSLV; i++) begin
      if (idx == SW'(i)) begin
        pready_sel    = PREADY[i];
        pslverr_sel   = PSLVERR[i];
        prdata_sel    = PRDATA[i*DW +: DW];
        sel_onehot[i] = 1'b1;
      end
    end
  end

  // Next-state and bus-control decode.
  always_comb begin
    state_nxt   = state;
    req_ready   = 1'b0;
    PSEL        = '0;
    PENABLE     = 1'b0;
    access_done = 1'b0;
    timeout_hit = (cnt == TO_LAST) && !pready_sel;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = req_mapped ? SETUP : ERR;
      end
      SETUP: begin
        PSEL      = sel_onehot;
        state_nxt = ACCESS;
      end
      ACCESS: begin
        PSEL    = sel_onehot;
        PENABLE = 1'b1;
        if (pready_sel || timeout_hit) begin
          access_done = 1'b1;
          state_nxt   = IDLE;
        end
      end
      ERR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register; reset aborts any transfer in flight.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) state <= IDLE;
    else          state <= state_nxt;
  end

  // Request capture at acceptance and wait-state counter.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      cnt     <= '0;
    end else begin
      if (state == IDLE && req_valid) begin
        addr_q  <= req_addr;
        write_q <= req_write;
        wdata_q <= req_wdata;
      end
      if (state == ACCESS && !access_done) cnt <= cnt + CW'(1);
      else                                 cnt <= '0;
    end
  end

  // Registered completion: pulse one cycle after the ACCESS/ERR exit edge.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= access_done || (state == ERR);
      rsp_err   <= (state == ERR) || (access_done && (!pready_sel || pslverr_sel));
      rsp_rdata <= (access_done && pready_sel && !pslverr_sel && !write_q) ? prdata_sel : '0;
    end
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge: default instance plus a NSLV=3/TIMEOUT=4 instance.
// Expected responses are queued at acceptance and compared when rsp_valid pulses.
// All waits on the DUT are bounded by a cycle budget.
module tb_apb_master_bridge;

  typedef struct packed {
    logic [7:0] rd;
    logic       err;
  } rsp_t;

  logic PCLK;
  logic PRESETn;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  rsp_t sb_a[$];
  rsp_t sb_b[$];

  // Instance A: defaults (AW=9, DW=8, NSLV=2, TIMEOUT=16)
  logic        a_valid, a_ready, a_write, a_rsp_valid, a_rsp_err, a_penable, a_pwrite;
  logic [8:0]  a_addr;
  logic [7:0]  a_wdata, a_rsp_rdata, a_paddr, a_pwdata;
  logic [1:0]  a_psel, a_pready, a_pslverr;
  logic [15:0] a_prdata;

  // Instance B: NSLV=3, TIMEOUT=4
  logic        b_valid, b_ready, b_write, b_rsp_valid, b_rsp_err, b_penable, b_pwrite;
  logic [8:0]  b_addr;
  logic [7:0]  b_wdata, b_rsp_rdata, b_pwdata;
  logic [6:0]  b_paddr;
  logic [2:0]  b_psel, b_pready, b_pslverr;
  logic [23:0] b_prdata;

  apb_master_bridge dut_a (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .req_valid(a_valid), .req_ready(a_ready), .req_write(a_write),
    .req_addr(a_addr), .req_wdata(a_wdata),
    .rsp_valid(a_rsp_valid), .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err),
    .PSEL(a_psel), .PENABLE(a_penable), .PWRITE(a_pwrite), .PADDR(a_paddr),
    .PWDATA(a_pwdata), .PRDATA(a_prdata), .PREADY(a_pready), .PSLVERR(a_pslverr)
  );

  apb_master_bridge #(.AW(9), .DW(8), .NSLV(3), .TIMEOUT(4)) dut_b (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .req_valid(b_valid), .req_ready(b_ready), .req_write(b_write),
    .req_addr(b_addr), .req_wdata(b_wdata),
    .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err),
    .PSEL(b_psel), .PENABLE(b_penable), .PWRITE(b_pwrite), .PADDR(b_paddr),
    .PWDATA(b_pwdata), .PRDATA(b_prdata), .PREADY(b_pready), .PSLVERR(b_pslverr)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  always @(posedge PCLK) cyc <= cyc + 1;

  task automatic tick();
    @(negedge PCLK);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic xfer_a(input logic wr, input logic [8:0] addr, input logic [7:0] wd,
                        input int wait_n, input logic [7:0] exp_rd, input logic exp_err,
                        input int exp_lat, input int exp_en, input logic [1:0] exp_psel);
    int acc, en, n;
    rsp_t r;
    a_valid = 1'b1; a_write = wr; a_addr = addr; a_wdata = wd;
    chk("a_req_ready_accept", 32'(a_ready), 32'd1);
    sb_a.push_back({exp_rd, exp_err});
    acc = cyc; en = 0; n = 0;
    tick();
    a_valid = 1'b0; a_write = ~wr; a_addr = ~addr; a_wdata = ~wd;
    while (!a_rsp_valid && n < 40) begin
      chk("a_psel", 32'(a_psel), 32'(exp_psel));
      chk("a_req_ready_busy", 32'(a_ready), 32'd0);
      if (exp_psel != 2'b00) begin
        chk("a_paddr", 32'(a_paddr), 32'(addr[7:0]));
        chk("a_pwrite", 32'(a_pwrite), 32'(wr));
        chk("a_pwdata", 32'(a_pwdata), 32'(wd));
      end
      if (a_penable) begin
        en++;
        if (en == wait_n + 1) a_pready = a_pready | exp_psel;
      end
      tick();
      n++;
    end
    chk("a_rsp_seen", 32'(a_rsp_valid), 32'd1);
    chk("a_latency", 32'(cyc - acc), 32'(exp_lat));
    chk("a_penable_cycles", 32'(en), 32'(exp_en));
    chk("a_psel_done", 32'(a_psel), 32'd0);
    chk("a_penable_done", 32'(a_penable), 32'd0);
    chk("a_req_ready_done", 32'(a_ready), 32'd1);
    chk("a_sb_nonempty", 32'(sb_a.size() != 0), 32'd1);
    if (sb_a.size() != 0) begin
      r = sb_a.pop_front();
      chk("a_rsp_rdata", 32'(a_rsp_rdata), 32'(r.rd));
      chk("a_rsp_err", 32'(a_rsp_err), 32'(r.err));
    end
    a_pready = a_pready & ~exp_psel;
  endtask

  task automatic xfer_b(input logic wr, input logic [8:0] addr, input logic [7:0] wd,
                        input int wait_n, input logic [7:0] exp_rd, input logic exp_err,
                        input int exp_lat, input int exp_en, input logic [2:0] exp_psel);
    int acc, en, n;
    rsp_t r;
    b_valid = 1'b1; b_write = wr; b_addr = addr; b_wdata = wd;
    chk("b_req_ready_accept", 32'(b_ready), 32'd1);
    sb_b.push_back({exp_rd, exp_err});
    acc = cyc; en = 0; n = 0;
    tick();
    b_valid = 1'b0; b_write = ~wr; b_addr = ~addr; b_wdata = ~wd;
    while (!b_rsp_valid && n < 40) begin
      chk("b_psel", 32'(b_psel), 32'(exp_psel));
      if (exp_psel != 3'b000) chk("b_paddr", 32'(b_paddr), 32'(addr[6:0]));
      if (b_penable) begin
        en++;
        if (en == wait_n + 1) b_pready = b_pready | exp_psel;
      end
      tick();
      n++;
    end
    chk("b_rsp_seen", 32'(b_rsp_valid), 32'd1);
    chk("b_latency", 32'(cyc - acc), 32'(exp_lat));
    chk("b_penable_cycles", 32'(en), 32'(exp_en));
    chk("b_psel_done", 32'(b_psel), 32'd0);
    chk("b_sb_nonempty", 32'(sb_b.size() != 0), 32'd1);
    if (sb_b.size() != 0) begin
      r = sb_b.pop_front();
      chk("b_rsp_rdata", 32'(b_rsp_rdata), 32'(r.rd));
      chk("b_rsp_err", 32'(b_rsp_err), 32'(r.err));
    end
    b_pready = b_pready & ~exp_psel;
  endtask

  initial begin
    PRESETn = 1'b1;
    a_valid = 0; a_write = 0; a_addr = '0; a_wdata = '0;
    a_pready = '0; a_pslverr = '0; a_prdata = '0;
    b_valid = 0; b_write = 0; b_addr = '0; b_wdata = '0;
    b_pready = '0; b_pslverr = '0; b_prdata = '0;
    #1 PRESETn = 1'b0;
    #1;
    // Reset state
    chk("rst_a_req_ready", 32'(a_ready), 32'd1);
    chk("rst_a_rsp_valid", 32'(a_rsp_valid), 32'd0);
    chk("rst_a_psel", 32'(a_psel), 32'd0);
    chk("rst_a_penable", 32'(a_penable), 32'd0);
    chk("rst_a_paddr", 32'(a_paddr), 32'd0);
    chk("rst_a_pwdata", 32'(a_pwdata), 32'd0);
    chk("rst_a_pwrite", 32'(a_pwrite), 32'd0);
    chk("rst_a_rsp_err", 32'(a_rsp_err), 32'd0);
    chk("rst_b_req_ready", 32'(b_ready), 32'd1);
    chk("rst_b_psel", 32'(b_psel), 32'd0);
    tick(); tick();
    PRESETn = 1'b1;
    tick();

    // Write 0x005 / 0x0A, zero wait states
    xfer_a(1'b1, 9'h005, 8'h0A, 0, 8'h00, 1'b0, 3, 1, 2'b01);
    tick();
    chk("a_rsp_single_pulse", 32'(a_rsp_valid), 32'd0);
    chk("a_idle_psel", 32'(a_psel), 32'd0);
    chk("a_idle_penable", 32'(a_penable), 32'd0);
    chk("a_idle_paddr_hold", 32'(a_paddr), 32'h05);
    chk("a_idle_pwdata_hold", 32'(a_pwdata), 32'h0A);

    // Read 0x105 from slave1 with 3 wait states; slave0 ready/data must be ignored
    a_prdata = {8'h5A, 8'h33};
    a_pready = 2'b01;
    xfer_a(1'b0, 9'h105, 8'hC4, 3, 8'h5A, 1'b0, 6, 4, 2'b10);
    a_pready = 2'b00;
    tick();

    // Slave error on a write, then a back-to-back read in the rsp cycle
    a_pslverr = 2'b01;
    xfer_a(1'b1, 9'h010, 8'h77, 0, 8'h00, 1'b1, 3, 1, 2'b01);
    a_pslverr = 2'b10;
    a_prdata  = {8'hEE, 8'hC3};
    xfer_a(1'b0, 9'h0AA, 8'h00, 1, 8'hC3, 1'b0, 4, 2, 2'b01);
    a_pslverr = 2'b00;
    tick();

    // Unmapped slave index 3 on the three-slave instance
    xfer_b(1'b0, 9'h1C0, 8'h00, 0, 8'h00, 1'b1, 2, 0, 3'b000);
    tick();

    // Timeout: slave0 never ready; others ready and must be ignored
    b_pready = 3'b110;
    b_prdata = {8'h44, 8'h55, 8'h99};
    xfer_b(1'b0, 9'h040, 8'h00, 99, 8'h00, 1'b1, 6, 4, 3'b001);
    b_pready = 3'b000;
    tick();

    // Ready arrives in the last allowed ACCESS cycle: success, not timeout
    b_prdata = {8'hE7, 8'h11, 8'h22};
    xfer_b(1'b0, 9'h123, 8'h00, 3, 8'hE7, 1'b0, 6, 4, 3'b100);
    tick();

    // Reset in the middle of ACCESS
    a_valid = 1'b1; a_write = 1'b0; a_addr = 9'h105; a_wdata = 8'h00;
    tick();
    a_valid = 1'b0;
    tick();
    chk("a_mid_penable", 32'(a_penable), 32'd1);
    #2 PRESETn = 1'b0;
    #1;
    chk("a_rst_mid_psel", 32'(a_psel), 32'd0);
    chk("a_rst_mid_penable", 32'(a_penable), 32'd0);
    chk("a_rst_mid_rsp", 32'(a_rsp_valid), 32'd0);
    tick();
    chk("a_rst_hold_rsp", 32'(a_rsp_valid), 32'd0);
    PRESETn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("a_post_rst_rsp", 32'(a_rsp_valid), 32'd0);
      chk("a_post_rst_ready", 32'(a_ready), 32'd1);
      chk("a_post_rst_psel", 32'(a_psel), 32'd0);
    end

    // Bridge still works after reset recovery
    xfer_a(1'b1, 9'h0FF, 8'h3C, 0, 8'h00, 1'b0, 3, 1, 2'b01);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
